// File: rtl/rca_pkg.sv
// rca_pkg: shared defaults, slice-width helper and configuration check for the pipelined ripple-carry adder
package rca_pkg;
  localparam int N_DEF = 32;
  localparam int STAGES_DEF = 4;
  function automatic int slice_w(input int n, input int stages);
    return n / stages;
  endfunction
  function automatic bit cfg_ok(input int n, input int stages);
    return stages >= 1 && stages <= n && n % stages == 0;
  endfunction
endpackage

// File: rtl/rca_if.sv
// rca_if: operand/result handshake bundle; master drives in_valid/A/B/Ci/Sub/out_ready, slave drives in_ready/out_valid/S/Co/Ovf
interface rca_if import rca_pkg::*; #(parameter int N = N_DEF);
  logic in_valid, in_ready, Ci, Sub, out_valid, out_ready, Co, Ovf;
  logic [N-1:0] A, B, S;
  modport master (output in_valid, A, B, Ci, Sub, out_ready, input in_ready, out_valid, S, Co, Ovf);
  modport slave (input in_valid, A, B, Ci, Sub, out_ready, output in_ready, out_valid, S, Co, Ovf);
endinterface

// File: rtl/rca_slice.sv
// rca_slice: combinational W-bit full-adder ripple; a/b/ci in, s/co out, c_msb = carry into the top bit
module rca_slice #(parameter int W = 8) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);
  logic [W:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i] = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co = c[W];
  assign c_msb = c[W-1];
endmodule

// File: rtl/rca_pipe.sv
// rca_pipe: STAGES-deep pipelined add/sub (clk, async rst, rca_if slave bus) with valid/ready backpressure and bubble collapse
module rca_pipe import rca_pkg::*; #(
  parameter int N = N_DEF,
  parameter int STAGES = STAGES_DEF
) (
  input logic  clk,
  input logic  rst,
  rca_if.slave bus
);
  localparam int W = slice_w(N, STAGES);
  typedef struct packed {logic [N-1:0] s; logic co; logic ovf;} res_t;
  if (!cfg_ok(N, STAGES)) begin : g_bad_cfg
    $error("rca_pipe: N must be a multiple of STAGES and STAGES in 1..N");
  end
  logic [STAGES-1:0] v_q, v_in, adv, c_q, co_w, c_in;
  logic [N-1:0] x_q [STAGES];
  logic [N-1:0] y_q [STAGES];
  logic [N-1:0] a_in [STAGES];
  logic [N-1:0] b_in [STAGES];
  logic [N-1:0] x_d [STAGES];
  logic [W-1:0] s_w [STAGES];
  logic cm_w [STAGES];
  logic ovf_q;
  res_t res;
  // x carries finished sum slices below and including k, untouched A slices above; y carries B'
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam logic [N-1:0] M = N'({W{1'b1}}) << (k * W);
    rca_slice #(.W(W)) u_slice (
      .a(a_in[k][k*W +: W]), .b(b_in[k][k*W +: W]), .ci(c_in[k]),
      .s(s_w[k]), .co(co_w[k]), .c_msb(cm_w[k])
    );
    assign x_d[k] = (a_in[k] & ~M) | (N'(s_w[k]) << (k * W));
    // a stage may load when it is empty or everything downstream of it can move
    assign adv[k] = bus.out_ready | ~&v_q[STAGES-1:k];
    if (k == 0) begin : g_first
      assign a_in[0] = bus.A;
      assign b_in[0] = bus.Sub ? ~bus.B : bus.B;
      assign c_in[0] = bus.Sub | bus.Ci;
      assign v_in[0] = bus.in_valid;
    end else begin : g_next
      assign a_in[k] = x_q[k-1];
      assign b_in[k] = y_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign v_in[k] = v_q[k-1];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++)
        if (adv[k]) begin
          v_q[k] <= v_in[k];
          x_q[k] <= x_d[k];
          y_q[k] <= b_in[k];
          c_q[k] <= co_w[k];
        end
      if (adv[STAGES-1]) ovf_q <= cm_w[STAGES-1] ^ co_w[STAGES-1];
    end
  assign res = '{s: x_q[STAGES-1], co: c_q[STAGES-1], ovf: ovf_q};
  assign bus.in_ready = adv[0];
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.S = res.s;
  assign bus.Co = res.co;
  assign bus.Ovf = res.ovf;
endmodule

// File: tb/tb_rca_pipe.sv
// tb_rca_pipe: directed and randomized checks of rca_pipe (N=8, STAGES 1/2/8) against an arithmetic model
module tb_rca_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  rca_if #(.N(8)) if1 (), if2 (), if8 ();
  rca_pipe #(.N(8), .STAGES(1)) u_s1 (.clk(clk), .rst(rst), .bus(if1.slave));
  rca_pipe #(.N(8), .STAGES(2)) u_s2 (.clk(clk), .rst(rst), .bus(if2.slave));
  rca_pipe #(.N(8), .STAGES(8)) u_s8 (.clk(clk), .rst(rst), .bus(if8.slave));
  int n_chk = 0;
  int n_pass = 0;
  logic [9:0] q1[$], q2[$], q8[$], bpx[$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  // {Ovf, Co, S} from integer arithmetic on the operand values
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sub);
    int sa, sb, sx, ux;
    logic co, ovf;
    sa = $signed(a);
    sb = $signed(b);
    sx = sub ? sa - sb : sa + sb + int'(ci);
    ux = sub ? int'(a) - int'(b) : int'(a) + int'(b) + int'(ci);
    co = sub ? (a >= b) : (ux > 255);
    ovf = sx < -128 || sx > 127;
    return {ovf, co, ux[7:0]};
  endfunction
  task automatic chk_reset(input string tag);
    check({tag, "_out_valid"}, if2.out_valid, 0);
    check({tag, "_S"}, if2.S, 0);
    check({tag, "_Co"}, if2.Co, 0);
    check({tag, "_Ovf"}, if2.Ovf, 0);
    check({tag, "_in_ready"}, if2.in_ready, 1);
  endtask
  task automatic op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sub, input logic [9:0] exp);
    @(negedge clk);
    if2.A = a; if2.B = b; if2.Ci = ci; if2.Sub = sub; if2.in_valid = 1; if2.out_ready = 1;
    #1 check({tag, "_in_ready"}, if2.in_ready, 1);
    @(negedge clk);
    if2.in_valid = 0;
    check({tag, "_early"}, if2.out_valid, 0);
    @(negedge clk);
    check({tag, "_out_valid"}, if2.out_valid, 1);
    check(tag, {if2.Ovf, if2.Co, if2.S}, exp);
  endtask
  task automatic sb(input string tag, ref logic [9:0] q[$], input logic ov, input logic ordy,
                    input logic iv, input logic ir, input logic [9:0] got, input logic [9:0] exp);
    if (ov && ordy) begin
      check({tag, "_expected_pending"}, q.size() > 0, 1);
      if (q.size() > 0) check(tag, got, q.pop_front());
    end
    if (iv && ir) q.push_back(exp);
  endtask
  initial begin
    logic [7:0] a, b;
    logic ci, sub, iv, ordy;
    int acc, got;
    {if1.in_valid, if2.in_valid, if8.in_valid} = '0;
    {if1.out_ready, if2.out_ready, if8.out_ready} = '1;
    {if1.A, if2.A, if8.A, if1.B, if2.B, if8.B} = '0;
    {if1.Ci, if2.Ci, if8.Ci, if1.Sub, if2.Sub, if8.Sub} = '0;
    repeat (3) @(negedge clk);
    rst = 0;
    #1 chk_reset("rst_init");
    op("add_wrap", 8'hFF, 8'h01, 0, 0, {1'b0, 1'b1, 8'h00});
    op("sub_neg", 8'h05, 8'h07, 0, 1, {1'b0, 1'b0, 8'hFE});
    op("sub_ovf", 8'h80, 8'h01, 0, 1, {1'b1, 1'b1, 8'h7F});
    op("add_ovf", 8'h7F, 8'h01, 0, 0, {1'b1, 1'b0, 8'h80});
    op("sub_ci_ignored", 8'h10, 8'h10, 1, 1, {1'b0, 1'b1, 8'h00});
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1 chk_reset("rst_mid");
    acc = 0;
    got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      @(negedge clk);
      if2.in_valid = acc < 5;
      if2.A = 8'(acc * 37 + 200); if2.B = 8'(acc * 59 + 13); if2.Ci = acc[0]; if2.Sub = acc[1];
      if2.out_ready = c >= 4;
      #1;
      if (c == 2 || c == 3) begin
        check("bp_in_ready", if2.in_ready, 0);
        check("bp_hold", {if2.out_valid, if2.Ovf, if2.Co, if2.S}, {1'b1, bpx.size() > 0 ? bpx[0] : 10'h3FF});
      end
      if (if2.out_valid && if2.out_ready) begin
        check($sformatf("bp_out%0d", got), {if2.Ovf, if2.Co, if2.S}, bpx.size() > 0 ? bpx.pop_front() : 10'h3FF);
        got++;
      end
      if (if2.in_valid && if2.in_ready) begin
        bpx.push_back(model(if2.A, if2.B, if2.Ci, if2.Sub));
        acc++;
      end
    end
    check("bp_count", got, 5);
    @(negedge clk);
    if2.in_valid = 1; if2.out_ready = 1; if2.A = 8'h10; if2.B = 8'h20; if2.Sub = 0; if2.Ci = 0;
    @(negedge clk);
    if2.A = 8'h30; if2.B = 8'h40;
    @(negedge clk);
    if2.in_valid = 0; if2.out_ready = 0;
    check("rst_pre_out_valid", if2.out_valid, 1);
    #1 rst = 1;
    #1 check("rst_async_out_valid", if2.out_valid, 0);
    check("rst_async_S", if2.S, 0);
    @(negedge clk);
    rst = 0;
    if2.out_ready = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rst_no_stale", if2.out_valid, 0);
    end
    op("post_rst", 8'h21, 8'h0F, 1, 0, {1'b0, 1'b0, 8'h31});
    for (int c = 0; c < 7000 + 20; c++) begin
      @(negedge clk);
      a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom); sub = 1'($urandom);
      iv = c < 7000 && $urandom_range(0, 3) != 0;
      ordy = c >= 7000 || $urandom_range(0, 3) != 0;
      {if1.A, if2.A, if8.A} = {3{a}};
      {if1.B, if2.B, if8.B} = {3{b}};
      {if1.Ci, if2.Ci, if8.Ci} = {3{ci}};
      {if1.Sub, if2.Sub, if8.Sub} = {3{sub}};
      {if1.in_valid, if2.in_valid, if8.in_valid} = {3{iv}};
      {if1.out_ready, if2.out_ready, if8.out_ready} = {3{ordy}};
      #1;
      sb("rnd_s1", q1, if1.out_valid, ordy, iv, if1.in_ready, {if1.Ovf, if1.Co, if1.S}, model(a, b, ci, sub));
      sb("rnd_s2", q2, if2.out_valid, ordy, iv, if2.in_ready, {if2.Ovf, if2.Co, if2.S}, model(a, b, ci, sub));
      sb("rnd_s8", q8, if8.out_valid, ordy, iv, if8.in_ready, {if8.Ovf, if8.Co, if8.S}, model(a, b, ci, sub));
    end
    check("rnd_s1_lost", q1.size(), 0);
    check("rnd_s2_lost", q2.size(), 0);
    check("rnd_s8_lost", q8.size(), 0);
    check("rnd_s8_drained", if8.out_valid, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
